// File: rtl/pipeline_trace_buffer.sv
// On-chip trace buffer: captures write-back records into a circular buffer, stops a fixed
// number of records after a PC trigger, then streams the window out oldest-first.
// Optional macro TRACE_FILTER_REGWR_EN: only records with cap_reg_wr=1 are captured.
module pipeline_trace_buffer #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         clear,
    input  logic                         arm,
    input  logic [XLEN-1:0]              trig_pc,
    input  logic                         cap_valid,
    input  logic [XLEN-1:0]              cap_pc,
    input  logic [31:0]                  cap_instr,
    input  logic [4:0]                   cap_rd,
    input  logic [XLEN-1:0]              cap_wb_data,
    input  logic                         cap_reg_wr,
    input  logic                         rd_ready,
    output logic                         rd_valid,
    output logic [XLEN-1:0]              rd_pc,
    output logic [31:0]                  rd_instr,
    output logic [4:0]                   rd_rd,
    output logic [XLEN-1:0]              rd_data,
    output logic                         rd_reg_wr,
    output logic                         rd_last,
    output logic [1:0]                   state,
    output logic [$clog2(DEPTH+1)-1:0]   fill,
    output logic                         wrapped
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle = 2'b00, StArmed = 2'b01, StPost = 2'b10, StDone = 2'b11}
        state_e;

    state_e          state_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [FW-1:0]   fill_q;
    logic [FW-1:0]   post_cnt_q;
    logic            wrapped_q;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic [4:0]      rd_mem    [DEPTH];
    logic [XLEN-1:0] data_mem  [DEPTH];
    logic            regwr_mem [DEPTH];

    logic            capture;
    logic            wr_en;
    logic            rd_fire;
    logic [FW-1:0]   fill_inc;
    logic [AW-1:0]   oldest_ptr;

    always_comb begin
        capture = enable && cap_valid;
`ifdef TRACE_FILTER_REGWR_EN
        capture = capture && cap_reg_wr;
`endif
        wr_en    = capture && !clear && (state_q == StArmed || state_q == StPost);
        fill_inc = (fill_q == FW'(DEPTH)) ? fill_q : fill_q + FW'(1);
        // Oldest entry once the current write lands; DEPTH truncates to 0 mod DEPTH.
        oldest_ptr = wr_ptr_q + AW'(1) - AW'(fill_inc);
    end

    assign rd_valid  = (state_q == StDone) && (fill_q != '0);
    assign rd_last   = rd_valid && (fill_q == FW'(1));
    assign rd_fire   = rd_valid && rd_ready;
    assign rd_pc     = pc_mem[rd_ptr_q];
    assign rd_instr  = instr_mem[rd_ptr_q];
    assign rd_rd     = rd_mem[rd_ptr_q];
    assign rd_data   = data_mem[rd_ptr_q];
    assign rd_reg_wr = regwr_mem[rd_ptr_q];
    assign state     = state_q;
    assign fill      = fill_q;
    assign wrapped   = wrapped_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr_q]    <= cap_pc;
            instr_mem[wr_ptr_q] <= cap_instr;
            rd_mem[wr_ptr_q]    <= cap_rd;
            data_mem[wr_ptr_q]  <= cap_wb_data;
            regwr_mem[wr_ptr_q] <= cap_reg_wr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            post_cnt_q <= '0;
            wrapped_q  <= 1'b0;
        end else if (clear) begin
            state_q    <= StIdle;
            fill_q     <= '0;
            post_cnt_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                fill_q   <= fill_inc;
                if (fill_q == FW'(DEPTH)) begin
                    wrapped_q <= 1'b1;
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (arm) begin
                        state_q   <= StArmed;
                        fill_q    <= '0;
                        wrapped_q <= 1'b0;
                    end
                end
                StArmed: begin
                    if (wr_en && cap_pc == trig_pc) begin
                        if (POST_TRIG == 0) begin
                            state_q  <= StDone;
                            rd_ptr_q <= oldest_ptr;
                        end else begin
                            state_q    <= StPost;
                            post_cnt_q <= FW'(POST_TRIG);
                        end
                    end
                end
                StPost: begin
                    if (wr_en) begin
                        post_cnt_q <= post_cnt_q - FW'(1);
                        if (post_cnt_q == FW'(1)) begin
                            state_q  <= StDone;
                            rd_ptr_q <= oldest_ptr;
                        end
                    end
                end
                StDone: begin
                    if (rd_fire) begin
                        rd_ptr_q <= rd_ptr_q + AW'(1);
                        fill_q   <= fill_q - FW'(1);
                        if (fill_q == FW'(1)) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Scoreboard bench for pipeline_trace_buffer (DEPTH=8, POST_TRIG=2); also follows
// TRACE_FILTER_REGWR_EN when the bundle is built with it.
module tb_pipeline_trace_buffer;

    localparam int unsigned Depth    = 8;
    localparam int unsigned PostTrig = 2;
    localparam logic [1:0] StIdle  = 2'b00;
    localparam logic [1:0] StArmed = 2'b01;
    localparam logic [1:0] StPost  = 2'b10;
    localparam logic [1:0] StDone  = 2'b11;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        reg_wr;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b1;
    logic        clear = 1'b0;
    logic        arm = 1'b0;
    logic [31:0] trig_pc = '0;
    logic        cap_valid = 1'b0;
    logic [31:0] cap_pc = '0;
    logic [31:0] cap_instr = '0;
    logic [4:0]  cap_rd = '0;
    logic [31:0] cap_wb_data = '0;
    logic        cap_reg_wr = 1'b0;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [31:0] rd_pc;
    logic [31:0] rd_instr;
    logic [4:0]  rd_rd;
    logic [31:0] rd_data;
    logic        rd_reg_wr;
    logic        rd_last;
    logic [1:0]  state;
    logic [3:0]  fill;
    logic        wrapped;

    int   total = 0;
    int   bad = 0;
    rec_t sb[$];
    logic [1:0] m_state = StIdle;
    int   m_post = 0;
    bit   pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    pipeline_trace_buffer #(
        .XLEN      (32),
        .DEPTH     (Depth),
        .POST_TRIG (PostTrig)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .clear       (clear),
        .arm         (arm),
        .trig_pc     (trig_pc),
        .cap_valid   (cap_valid),
        .cap_pc      (cap_pc),
        .cap_instr   (cap_instr),
        .cap_rd      (cap_rd),
        .cap_wb_data (cap_wb_data),
        .cap_reg_wr  (cap_reg_wr),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_pc       (rd_pc),
        .rd_instr    (rd_instr),
        .rd_rd       (rd_rd),
        .rd_data     (rd_data),
        .rd_reg_wr   (rd_reg_wr),
        .rd_last     (rd_last),
        .state       (state),
        .fill        (fill),
        .wrapped     (wrapped)
    );

    always #5 clk = ~clk;

    // Readout monitor: compares every visible beat against the scoreboard head.
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_pc = '0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_valid = 1'b0;
        end else begin
            if (rd_valid) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL beat_unexpected: rd_pc=%h rd_valid=%b, none expected",
                             rd_pc, rd_valid);
                end else begin
                    rec_t exp_r;
                    rec_t got_r;
                    exp_r = sb[0];
                    got_r = '{rd_pc, rd_instr, rd_rd, rd_data, rd_reg_wr};
                    if (got_r !== exp_r) begin
                        bad++;
                        $display("FAIL beat_data: got %h expected %h", got_r, exp_r);
                    end
                    total++;
                    if (rd_last !== (sb.size() == 1)) begin
                        bad++;
                        $display("FAIL beat_last: rd_last=%b expected %b pc=%h",
                                 rd_last, sb.size() == 1, exp_r.pc);
                    end
                    if (prev_valid && !prev_ready) begin
                        total++;
                        if (rd_pc !== prev_pc) begin
                            bad++;
                            $display("FAIL stall_hold: rd_pc=%h expected %h", rd_pc, prev_pc);
                        end
                    end
                    if (rd_ready) void'(sb.pop_front());
                end
            end
            prev_valid = rd_valid;
            prev_ready = rd_ready;
            prev_pc    = rd_pc;
        end
    end

    task automatic do_arm();
        arm = 1'b1;
        if (m_state == StIdle) begin
            m_state = StArmed;
            sb.delete();
        end
        @(posedge clk); #1;
        arm = 1'b0;
    endtask

    // Drives one capture record for one cycle and updates the reference model.
    task automatic feed(input logic [31:0] pc, input logic rw, input logic en);
        rec_t r;
        logic acc;
        r = '{pc, {pc[15:0], 16'h0013}, pc[6:2], pc ^ 32'hDEAD_BEEF, rw};
        cap_valid   = 1'b1;
        cap_pc      = r.pc;
        cap_instr   = r.instr;
        cap_rd      = r.rd;
        cap_wb_data = r.data;
        cap_reg_wr  = rw;
        enable      = en;
        acc = en && (m_state == StArmed || m_state == StPost);
`ifdef TRACE_FILTER_REGWR_EN
        acc = acc && rw;
`endif
        if (clear) begin
            m_state = StIdle;
            sb.delete();
        end else if (acc) begin
            sb.push_back(r);
            if (sb.size() > Depth) void'(sb.pop_front());
            if (m_state == StArmed && pc == trig_pc) begin
                m_state = (PostTrig == 0) ? StDone : StPost;
                m_post  = PostTrig;
            end else if (m_state == StPost) begin
                m_post--;
                if (m_post == 0) m_state = StDone;
            end
        end
        @(posedge clk); #1;
        cap_valid = 1'b0;
        enable    = 1'b1;
    endtask

    task automatic drain(input bit stall);
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            rd_ready = stall ? pat[i % 4] : 1'b1;
            @(posedge clk); #1;
        end
        rd_ready = 1'b0;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", sb.size());
            sb.delete();
        end
        m_state = StIdle;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({state, fill, wrapped, rd_valid, rd_last} !== 9'b0) begin
            bad++;
            $display("FAIL reset_state: state=%b fill=%0d wrapped=%b rd_valid=%b rd_last=%b",
                     state, fill, wrapped, rd_valid, rd_last);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        trig_pc = 32'h08;
        do_arm();
        total++;
        if (state !== StArmed || fill !== 4'd0) begin
            bad++;
            $display("FAIL arm_state: state=%b fill=%0d expected 01/0", state, fill);
        end
        for (int i = 0; i < 5; i++) begin
            feed(32'(i * 4), 1'b1, 1'b1);
            total++;
            if (state !== m_state || fill !== 4'(sb.size())) begin
                bad++;
                $display("FAIL basic_feed%0d: state=%b fill=%0d expected %b/%0d",
                         i, state, fill, m_state, sb.size());
            end
        end
        total++;
        if (state !== StDone || fill !== 4'd5 || wrapped !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: state=%b fill=%0d wrapped=%b expected 11/5/0",
                     state, fill, wrapped);
        end
        drain(1'b0);
        total++;
        if (state !== StIdle || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle: state=%b rd_valid=%b expected 00/0", state, rd_valid);
        end
    endtask

    task automatic test_wrap();
        trig_pc = 32'h24;
        do_arm();
        for (int i = 0; i < 12; i++) feed(32'(i * 4), 1'b1, 1'b1);
        total++;
        if (state !== StDone || fill !== 4'd8 || wrapped !== 1'b1) begin
            bad++;
            $display("FAIL wrap_done: state=%b fill=%0d wrapped=%b expected 11/8/1",
                     state, fill, wrapped);
        end
        total++;
        if (rd_pc !== 32'h10) begin
            bad++;
            $display("FAIL wrap_oldest: rd_pc=%h expected 00000010", rd_pc);
        end
        drain(1'b0);
    endtask

    task automatic test_stall();
        trig_pc = 32'h20C;
        do_arm();
        for (int i = 0; i < 6; i++) feed(32'h200 + 32'(i * 4), 1'b1, 1'b1);
        total++;
        if (state !== StDone || fill !== 4'd6) begin
            bad++;
            $display("FAIL stall_done: state=%b fill=%0d expected 11/6", state, fill);
        end
        drain(1'b1);
        total++;
        if (state !== StIdle) begin
            bad++;
            $display("FAIL stall_idle: state=%b expected 00", state);
        end
    endtask

    task automatic test_enable();
        trig_pc = 32'h40;
        do_arm();
        feed(32'h40, 1'b1, 1'b0);
        total++;
        if (state !== StArmed || fill !== 4'd0) begin
            bad++;
            $display("FAIL gated_trig: state=%b fill=%0d expected 01/0", state, fill);
        end
        feed(32'h3C, 1'b1, 1'b1);
        feed(32'h40, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) feed(32'h44 + 32'(i * 4), 1'b1, 1'b0);
        total++;
        if (state !== StPost || fill !== 4'd2) begin
            bad++;
            $display("FAIL enable_hold: state=%b fill=%0d expected 10/2", state, fill);
        end
        feed(32'h50, 1'b1, 1'b1);
        total++;
        if (state !== StPost) begin
            bad++;
            $display("FAIL enable_post1: state=%b expected 10", state);
        end
        feed(32'h54, 1'b1, 1'b1);
        total++;
        if (state !== StDone || fill !== 4'd4) begin
            bad++;
            $display("FAIL enable_done: state=%b fill=%0d expected 11/4", state, fill);
        end
        drain(1'b0);
    endtask

    task automatic test_abort();
        trig_pc = 32'h300;
        do_arm();
        feed(32'h2F0, 1'b1, 1'b1);
        feed(32'h300, 1'b1, 1'b1);
        clear = 1'b1;
        arm   = 1'b1;
        feed(32'h304, 1'b1, 1'b1);
        clear = 1'b0;
        arm   = 1'b0;
        total++;
        if (state !== StIdle || fill !== 4'd0 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL clear_post: state=%b fill=%0d rd_valid=%b expected 00/0/0",
                     state, fill, rd_valid);
        end
        trig_pc = 32'h400;
        do_arm();
        for (int i = 0; i < 3; i++) feed(32'h400 + 32'(i * 4), 1'b1, 1'b1);
        rd_ready = 1'b1;
        @(posedge clk); #3;
        rd_ready = 1'b0;
        rst = 1'b0;
        #1;
        total++;
        if (rd_valid !== 1'b0 || state !== StIdle || fill !== 4'd0) begin
            bad++;
            $display("FAIL reset_readout: rd_valid=%b state=%b fill=%0d expected 0/00/0",
                     rd_valid, state, fill);
        end
        sb.delete();
        m_state = StIdle;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_filter();
        logic [31:0] pcs[8] = '{32'h80, 32'h84, 32'h100, 32'h88, 32'h100, 32'h8C, 32'h90, 32'h94};
        logic        rws[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        trig_pc = 32'h100;
        do_arm();
        for (int i = 0; i < 8; i++) begin
            feed(pcs[i], rws[i], 1'b1);
            total++;
            if (state !== m_state || fill !== 4'(sb.size())) begin
                bad++;
                $display("FAIL filter_feed%0d: state=%b fill=%0d expected %b/%0d",
                         i, state, fill, m_state, sb.size());
            end
        end
        drain(1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_enable();
        test_abort();
        test_filter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
